// File: rtl/capi_reset_seq_pkg.sv
// Shared definitions for the CAPI PSL-side reset sequencer.
// Provides the 3-bit state encoding, debug/counter widths and the
// sequencing-counter width helper.
package capi_reset_seq_pkg;

    localparam int unsigned SEQ_STATE_W = 3;
    localparam int unsigned LOSS_CNT_W  = 8;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_GAP       = 3'd4,
        ST_RUN       = 3'd5,
        ST_HOLD      = 3'd6
    } seq_state_e;

    // Width wide enough that the shared counter never wraps for any interval.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return 32'($clog2(m)) + 32'd1;
    endfunction

endpackage

// File: rtl/capi_reset_sync.sv
// Two-flop synchronizer with synchronous active-high clear.
// Ports:
//   CLK      - destination clock
//   clr      - synchronous clear, forces both stages to 0
//   async_in - asynchronous input
//   sync_out - synchronized output (2 CLK cycles of latency)
module capi_reset_sync (
    input  logic CLK,
    input  logic clr,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (clr) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/capi_reset_sequencer.sv
// Ordered reset release for the PSL-side domains after PLL lock is stable,
// with re-assertion on lock loss and a request/ack soft reset.
// Optional: define CAPI_RESET_SEQ_LOSS_CNT_EN to add the LOSS_CNT output.
// Ports:
//   CLK          - sole clock
//   RESET        - synchronous active-high block reset
//   PLL_LOCKED   - asynchronous PLL lock, synchronized internally
//   SOFT_RST_REQ - level soft-reset request, honoured only in RUN
//   SOFT_RST_ACK - one-cycle pulse when a soft reset completes or aborts
//   DOM_RESET    - per-domain active-high resets, released in index order
//   READY        - high only in RUN
//   LOSS_CNT     - (optional) saturating count of lock-loss aborts
//   SEQ_STATE    - current state encoding for debug
module capi_reset_sequencer
    import capi_reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOM     = 4,
    parameter int unsigned LOCK_STABLE = 1000,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned SOFT_HOLD   = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   PLL_LOCKED,
    input  logic                   SOFT_RST_REQ,
    output logic                   SOFT_RST_ACK,
    output logic [NUM_DOM-1:0]     DOM_RESET,
    output logic                   READY,
`ifdef CAPI_RESET_SEQ_LOSS_CNT_EN
    output logic [LOSS_CNT_W-1:0]  LOSS_CNT,
`endif
    output logic [SEQ_STATE_W-1:0] SEQ_STATE
);

    localparam int unsigned CNT_W = cnt_width(LOCK_STABLE, GAP_CYCLES, SOFT_HOLD);
    localparam int unsigned IDX_W = (NUM_DOM > 1) ? 32'($clog2(NUM_DOM)) : 32'd1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOM - 1);

    logic               lock_s;
    seq_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [NUM_DOM-1:0] dom_q, dom_n;
    logic               ready_q, ready_n;
    logic               ack_q, ack_n;

    capi_reset_sync u_lock_sync (
        .CLK      (CLK),
        .clr      (RESET),
        .async_in (PLL_LOCKED),
        .sync_out (lock_s)
    );

    // State, counter, index and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            idx     <= '0;
            dom_q   <= '1;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            dom_q   <= dom_n;
            ready_q <= ready_n;
            ack_q   <= ack_n;
        end
    end

    // Next state; lock loss overrides soft request and count completion.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        case (state)
            ST_ASSERT:    state_n = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (lock_s) state_n = ST_STABLE;
            ST_STABLE: begin
                if (cnt == STABLE_LAST) begin
                    state_n = ST_RELEASE;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (idx == IDX_LAST) begin
                    state_n = ST_RUN;
                end else if (GAP_CYCLES == 0) begin
                    idx_n = idx + IDX_W'(1);
                end else begin
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = ST_RELEASE;
                    idx_n   = idx + IDX_W'(1);
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RUN:  if (SOFT_RST_REQ) state_n = ST_HOLD;
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n = ST_WAIT_LOCK;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = ST_ASSERT;
        endcase

        if (!lock_s && (state inside {ST_STABLE, ST_RELEASE, ST_GAP, ST_RUN, ST_HOLD})) begin
            state_n = ST_WAIT_LOCK;
            idx_n   = '0;
        end

        if (state_n != state) cnt_n = '0;
    end

    // Output next-values, keyed on the transition so they land on the entry edge.
    always_comb begin
        dom_n   = dom_q;
        ready_n = (state_n == ST_RUN);
        ack_n   = (state == ST_HOLD) && (state_n == ST_WAIT_LOCK);
        if (state_n inside {ST_ASSERT, ST_WAIT_LOCK, ST_HOLD}) begin
            dom_n = '1;
        end
        for (int unsigned i = 0; i < NUM_DOM; i++) begin
            if ((state_n == ST_RELEASE) && (idx_n == IDX_W'(i))) dom_n[i] = 1'b0;
        end
    end

`ifdef CAPI_RESET_SEQ_LOSS_CNT_EN
    logic loss_abort;
    assign loss_abort = !lock_s && (state inside {ST_RELEASE, ST_GAP, ST_RUN, ST_HOLD});

    // Saturating lock-loss abort counter; only RESET clears it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LOSS_CNT <= '0;
        end else if (loss_abort && (LOSS_CNT != '1)) begin
            LOSS_CNT <= LOSS_CNT + LOSS_CNT_W'(1);
        end
    end
`endif

    assign DOM_RESET    = dom_q;
    assign READY        = ready_q;
    assign SOFT_RST_ACK = ack_q;
    assign SEQ_STATE    = state;

endmodule

// File: tb/tb_capi_reset_sequencer.sv
// Bench for capi_reset_sequencer: a small-parameter instance driven by a
// cycle-by-cycle vector table, and a default-parameter instance exercised by
// hand-written multi-cycle sequences.
module tb_capi_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: default parameters.
    logic       rst1, lock1, req1, ack1, ready1;
    logic [3:0] dom1;
    logic [2:0] st1;
    // Instance 2: NUM_DOM=2, GAP_CYCLES=0, short intervals.
    logic       rst2, lock2, req2, ack2, ready2;
    logic [1:0] dom2;
    logic [2:0] st2;
`ifdef CAPI_RESET_SEQ_LOSS_CNT_EN
    logic [7:0] loss1, loss2;
`endif

    capi_reset_sequencer u_dut1 (
        .CLK          (clk),
        .RESET        (rst1),
        .PLL_LOCKED   (lock1),
        .SOFT_RST_REQ (req1),
        .SOFT_RST_ACK (ack1),
        .DOM_RESET    (dom1),
        .READY        (ready1),
`ifdef CAPI_RESET_SEQ_LOSS_CNT_EN
        .LOSS_CNT     (loss1),
`endif
        .SEQ_STATE    (st1)
    );

    capi_reset_sequencer #(
        .NUM_DOM     (2),
        .LOCK_STABLE (3),
        .GAP_CYCLES  (0),
        .SOFT_HOLD   (2)
    ) u_dut2 (
        .CLK          (clk),
        .RESET        (rst2),
        .PLL_LOCKED   (lock2),
        .SOFT_RST_REQ (req2),
        .SOFT_RST_ACK (ack2),
        .DOM_RESET    (dom2),
        .READY        (ready2),
`ifdef CAPI_RESET_SEQ_LOSS_CNT_EN
        .LOSS_CNT     (loss2),
`endif
        .SEQ_STATE    (st2)
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    typedef struct {
        logic [2:0] in;    // {rst, lock, req} applied before the edge
        logic [1:0] dom;   // expected DOM_RESET after the edge
        logic [1:0] rd_ak; // expected {READY, SOFT_RST_ACK}
        logic [2:0] st;    // expected SEQ_STATE
    } vec_t;

    vec_t vt[30];

    function automatic vec_t mk(input logic [2:0] i, input logic [1:0] d,
                                input logic [1:0] ra, input logic [2:0] s);
        vec_t v;
        v.in = i; v.dom = d; v.rd_ak = ra; v.st = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // 0..3: DOM_RESET[n] low, 4: READY, 5: ACK, 6: WAIT_LOCK, 7: STABLE
    function automatic logic cond1(input int which);
        case (which)
            0, 1, 2, 3: return dom1[2'(which)] == 1'b0;
            4:          return ready1;
            5:          return ack1;
            6:          return st1 == 3'd1;
            7:          return st1 == 3'd2;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic wait1(input int which, input string name, output int at);
        at = -1;
        for (int i = 0; i < 3000; i++) begin
            if (cond1(which)) begin
                at = edge_n;
                break;
            end
            tick();
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout got none expected event", name);
        end
    endtask

    initial begin
        int e0, a0, a1, a2, a3, ar, h, aa, f1, eb, s, nack;

        rst1 = 1'b1; lock1 = 1'b0; req1 = 1'b0;
        rst2 = 1'b1; lock2 = 1'b0; req2 = 1'b0;

        vt[0]  = mk(3'b100, 2'b11, 2'b00, 3'd0);
        vt[1]  = mk(3'b100, 2'b11, 2'b00, 3'd0);
        vt[2]  = mk(3'b010, 2'b11, 2'b00, 3'd1);
        vt[3]  = mk(3'b010, 2'b11, 2'b00, 3'd1);
        vt[4]  = mk(3'b010, 2'b11, 2'b00, 3'd2);
        vt[5]  = mk(3'b010, 2'b11, 2'b00, 3'd2);
        vt[6]  = mk(3'b010, 2'b11, 2'b00, 3'd2);
        vt[7]  = mk(3'b010, 2'b10, 2'b00, 3'd3);
        vt[8]  = mk(3'b010, 2'b00, 2'b00, 3'd3);
        vt[9]  = mk(3'b010, 2'b00, 2'b10, 3'd5);
        vt[10] = mk(3'b011, 2'b11, 2'b00, 3'd6);
        vt[11] = mk(3'b010, 2'b11, 2'b00, 3'd6);
        vt[12] = mk(3'b010, 2'b11, 2'b01, 3'd1);
        vt[13] = mk(3'b010, 2'b11, 2'b00, 3'd2);
        vt[14] = mk(3'b010, 2'b11, 2'b00, 3'd2);
        vt[15] = mk(3'b010, 2'b11, 2'b00, 3'd2);
        vt[16] = mk(3'b010, 2'b10, 2'b00, 3'd3);
        vt[17] = mk(3'b110, 2'b11, 2'b00, 3'd0);
        vt[18] = mk(3'b010, 2'b11, 2'b00, 3'd1);
        vt[19] = mk(3'b010, 2'b11, 2'b00, 3'd1);
        vt[20] = mk(3'b010, 2'b11, 2'b00, 3'd2);
        vt[21] = mk(3'b010, 2'b11, 2'b00, 3'd2);
        vt[22] = mk(3'b010, 2'b11, 2'b00, 3'd2);
        vt[23] = mk(3'b010, 2'b10, 2'b00, 3'd3);
        vt[24] = mk(3'b010, 2'b00, 2'b00, 3'd3);
        vt[25] = mk(3'b010, 2'b00, 2'b10, 3'd5);
        vt[26] = mk(3'b000, 2'b00, 2'b10, 3'd5);
        vt[27] = mk(3'b000, 2'b00, 2'b10, 3'd5);
        vt[28] = mk(3'b001, 2'b11, 2'b00, 3'd1);
        vt[29] = mk(3'b001, 2'b11, 2'b00, 3'd1);

        // Small instance: table-driven, one edge per vector.
        for (int i = 0; i < 30; i++) begin
            {rst2, lock2, req2} = vt[i].in;
            tick();
            check($sformatf("v%0d_dom", i),   32'(dom2),            32'(vt[i].dom));
            check($sformatf("v%0d_ready", i), 32'(ready2),          32'(vt[i].rd_ak[1]));
            check($sformatf("v%0d_ack", i),   32'(ack2),            32'(vt[i].rd_ak[0]));
            check($sformatf("v%0d_state", i), 32'(st2),             32'(vt[i].st));
        end
`ifdef CAPI_RESET_SEQ_LOSS_CNT_EN
        check("i2_loss_cnt", 32'(loss2), 32'd1);
`endif

        // Default instance: reset values.
        check("rst_state", 32'(st1),    32'd0);
        check("rst_dom",   32'(dom1),   32'hF);
        check("rst_ready", 32'(ready1), 32'd0);
        check("rst_ack",   32'(ack1),   32'd0);

        // Initial release sequence.
        rst1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        lock1 = 1'b1;
        e0 = edge_n + 1;
        wait1(0, "rel0", a0);
        check("rel0_from_lock", 32'(a0 - e0), 32'd1002);
        wait1(1, "rel1", a1);
        check("rel1_gap", 32'(a1 - a0), 32'd17);
        check("rel1_dom", 32'(dom1), 32'hC);
        wait1(2, "rel2", a2);
        check("rel2_gap", 32'(a2 - a1), 32'd17);
        wait1(3, "rel3", a3);
        check("rel3_gap", 32'(a3 - a2), 32'd17);
        check("rel3_dom", 32'(dom1), 32'h0);
        wait1(4, "ready", ar);
        check("ready_lat", 32'(ar - a3), 32'd1);
        check("run_state", 32'(st1), 32'd5);

        // Soft reset from RUN.
        req1 = 1'b1;
        tick();
        h = edge_n;
        req1 = 1'b0;
        check("hold_dom",   32'(dom1),   32'hF);
        check("hold_ready", 32'(ready1), 32'd0);
        check("hold_state", 32'(st1),    32'd6);
        wait1(5, "soft_ack", aa);
        check("soft_ack_time",  32'(aa - h), 32'd64);
        check("soft_ack_state", 32'(st1),    32'd1);
        tick();
        check("soft_ack_pulse", 32'(ack1), 32'd0);
        wait1(0, "rerel0", a0);
        check("rerel0_time", 32'(a0 - h), 32'd1065);
        wait1(1, "rerel1", a1);
        check("rerel1_gap", 32'(a1 - a0), 32'd17);

        // Lock loss between releases of domain 1 and domain 2.
        lock1 = 1'b0;
        f1 = edge_n;
        wait1(6, "gap_loss", s);
        check("gap_loss_time",  32'(s - f1),   32'd3);
        check("gap_loss_dom",   32'(dom1),     32'hF);
        check("gap_loss_ready", 32'(ready1),   32'd0);
`ifdef CAPI_RESET_SEQ_LOSS_CNT_EN
        check("loss_cnt_1", 32'(loss1), 32'd1);
`endif
        tick();
        tick();
        check("gap_loss_dom_held", 32'(dom1), 32'hF);

        // One-cycle lock drop mid-STABLE restarts the stability count.
        lock1 = 1'b1;
        wait1(7, "stable_entry", s);
        for (int i = 0; i < 500; i++) tick();
        lock1 = 1'b0;
        tick();
        lock1 = 1'b1;
        eb = edge_n + 1;
        tick();
        tick();
        check("drop_wait_lock", 32'(st1), 32'd1);
        check("drop_dom",       32'(dom1), 32'hF);
        wait1(0, "drop_rel0", a0);
        check("drop_rel0_time", 32'(a0 - eb), 32'd1002);
        wait1(4, "drop_ready", ar);

        // Lock loss 30 cycles into HOLD, request held high throughout.
        req1 = 1'b1;
        tick();
        h = edge_n;
        for (int i = 0; i < 27; i++) tick();
        lock1 = 1'b0;
        wait1(5, "hold_loss_ack", aa);
        check("hold_loss_time",  32'(aa - h), 32'd30);
        check("hold_loss_state", 32'(st1),    32'd1);
`ifdef CAPI_RESET_SEQ_LOSS_CNT_EN
        check("loss_cnt_2", 32'(loss1), 32'd2);
`endif
        nack = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (ack1) nack++;
        end
        check("hold_loss_single_ack", 32'(nack), 32'd0);
        check("req_ignored_state",    32'(st1),  32'd1);
        req1 = 1'b0;

        // RESET in the middle of a GAP.
        lock1 = 1'b1;
        wait1(0, "gap_rst_rel0", a0);
        for (int i = 0; i < 5; i++) tick();
        check("in_gap_state", 32'(st1), 32'd4);
        rst1 = 1'b1;
        tick();
        check("midrst_state", 32'(st1),    32'd0);
        check("midrst_dom",   32'(dom1),   32'hF);
        check("midrst_ready", 32'(ready1), 32'd0);
        check("midrst_ack",   32'(ack1),   32'd0);
`ifdef CAPI_RESET_SEQ_LOSS_CNT_EN
        check("midrst_loss", 32'(loss1), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
